// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared opcodes, immediate format codes and output buffer states
package imm_gen_pkg;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  typedef enum logic [2:0] {T_R, T_I, T_S, T_B, T_U, T_J, T_SHAMT, T_INV} imm_tipo_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RV32 immediate extraction and format classification
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instrucao,
  output logic [XLEN-1:0] imm,
  output imm_tipo_e       tipo,
  output logic            invalido
);
  logic [6:0] op;
  logic shift;
  logic [31:0] raw;
  logic [31:0] i;
  assign i = instrucao;
  assign op = i[6:0];
  assign shift = op == OP_IMM && i[13:12] == 2'b01;
  always_comb begin
    tipo = T_INV;
    case (op)
      OP_IMM:                      tipo = shift ? T_SHAMT : T_I;
      OP_LOAD, OP_JALR, OP_SYSTEM: tipo = T_I;
      OP_STORE:                    tipo = T_S;
      OP_BRANCH:                   tipo = T_B;
      OP_LUI, OP_AUIPC:            tipo = T_U;
      OP_JAL:                      tipo = T_J;
      OP_REG:                      tipo = T_R;
      default:                     tipo = T_INV;
    endcase
  end
  always_comb begin
    raw = tipo == T_I     ? {{20{i[31]}}, i[31:20]} :
          tipo == T_S     ? {{20{i[31]}}, i[31:25], i[11:7]} :
          tipo == T_B     ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
          tipo == T_U     ? {i[31:12], 12'b0} :
          tipo == T_J     ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
          tipo == T_SHAMT ? (XLEN == 64 ? {26'b0, i[25:20]} : {27'b0, i[24:20]}) :
                            32'b0;
    imm = XLEN'($signed(raw));
    invalido = tipo == T_INV;
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator with optional two-entry skid output buffer
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit REG_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instrucao,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_estendido,
  output logic [2:0]      imm_tipo,
  output logic            imm_invalido
);
  localparam int W = XLEN + 4;
  logic [XLEN-1:0] d_imm;
  imm_tipo_e d_tipo;
  logic d_inv;
  logic [W-1:0] dec;
  imm_decode #(.XLEN(XLEN)) u_dec (
    .instrucao(instrucao),
    .imm(d_imm),
    .tipo(d_tipo),
    .invalido(d_inv)
  );
  assign dec = {d_inv, d_tipo, d_imm};
  generate
    if (REG_OUT) begin : g_reg
      buf_state_e state, state_nx;
      logic [W-1:0] main_q, skid_q;
      logic accept, consume;
      assign accept = in_valid && in_ready;
      assign consume = out_valid && out_ready;
      always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else state <= state_nx;
      end
      always_comb begin
        state_nx = state == EMPTY ? (accept ? ONE : EMPTY) :
                   state == ONE   ? (accept && !consume ? FULL : !accept && consume ? EMPTY : ONE) :
                                    (consume ? ONE : FULL);
      end
      always_comb begin
        in_ready = state != FULL;
        out_valid = state != EMPTY;
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          main_q <= '0;
          skid_q <= '0;
        end else begin
          if (accept && (state == EMPTY || (state == ONE && consume))) main_q <= dec;
          else if (state == FULL && consume) main_q <= skid_q;
          if (state == ONE && accept && !consume) skid_q <= dec;
        end
      end
      assign {imm_invalido, imm_tipo, imm_estendido} = main_q;
    end else begin : g_comb
      assign in_ready = out_ready;
      assign out_valid = in_valid;
      assign {imm_invalido, imm_tipo, imm_estendido} = dec;
    end
  endgenerate
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64 only.
REQ-002 SHALL have parameter REG_OUT, default 1, selecting registered output (1) or combinational pass-through (0).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, instruction word present on instrucao.
REQ-006 SHALL have port in_ready, output, 1, block accepts instrucao this cycle.
REQ-007 SHALL have port instrucao, input, 32, raw RV32 instruction word.
REQ-008 SHALL have port out_valid, output, 1, result fields hold a decoded immediate.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes the result this cycle.
REQ-010 SHALL have port imm_estendido, output, XLEN, sign- or zero-extended immediate.
REQ-011 SHALL have port imm_tipo, output, 3, format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 invalid.
REQ-012 SHALL have port imm_invalido, output, 1, opcode not recognised.

Function
REQ-013 SHALL decode opcode from instrucao[6:0] internally; there is no separate opcode port.
REQ-014 SHALL produce I-format, sign-extended bits [31:20], for 0010011 (except shifts), 0000011, 1100111, 1110011.
REQ-015 SHALL produce SHAMT for 0010011 with funct3 001/101: zero-extended [24:20] when XLEN=32, [25:20] when XLEN=64.
REQ-016 SHALL produce S-format, sign-extended {[31:25],[11:7]}, for 0100011.
REQ-017 SHALL produce B-format, sign-extended {[31],[7],[30:25],[11:8],0}, for 1100011.
REQ-018 SHALL produce U-format {[31:12],12'b0}, sign-extended to XLEN, for 0110111 and 0010111.
REQ-019 SHALL produce J-format, sign-extended {[31],[19:12],[20],[30:21],0}, for 1101111.
REQ-020 SHALL output imm 0, tipo 0, invalido 0 for 0110011; imm 0, tipo 7, invalido 1 for any other opcode.
REQ-021 SHALL, when REG_OUT=1, give latency 1 cycle from accepted input (in_valid and in_ready) to out_valid.
REQ-022 SHALL, when REG_OUT=1, use a 2-entry output buffer (main + skid) with states EMPTY, ONE, FULL.
REQ-023 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL; in_ready is a registered state decode with no combinational path from out_ready.
REQ-024 SHALL make these transitions: EMPTY+accept->ONE; ONE+accept+consume->ONE; ONE+accept only->FULL; ONE+consume only->EMPTY; FULL+consume->ONE, skid moves to main.
REQ-025 SHALL hold out_valid and all result fields stable while out_valid=1 and out_ready=0.
REQ-026 SHALL deliver results in acceptance order, with none lost or duplicated.
REQ-027 SHALL, when REG_OUT=0, set in_ready=out_ready and out_valid=in_valid, and pass results combinationally.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, go to EMPTY: out_valid 0, in_ready 1 from the next cycle, imm_estendido 0, imm_tipo 0, imm_invalido 0.
REQ-029 SHALL discard any buffered or simultaneously offered instruction when reset is asserted mid-operation.

Structure
REQ-030 SHALL place opcode constants, the imm_tipo encoding and the buffer state encoding in a shared package, imm_gen_pkg.
REQ-031 SHALL put the combinational decode in one sub-module, imm_decode, instantiated once; the buffer logic lives in imm_gen_pipe.

Verification
REQ-032 SHALL check: 0xFFF17093 (ANDI) -> next cycle imm 0xFFFFFFFF, tipo 1, invalido 0.
REQ-033 SHALL check: 0xFE209E23 (SH -4) -> 0xFFFFFFFC, tipo 2; 0xFE209CE3 (BNE -8) -> 0xFFFFFFF8, tipo 3.
REQ-034 SHALL check: 0x123450B7 (LUI) with XLEN=32 -> 0x12345000; with XLEN=64 -> 0x0000000012345000, tipo 4.
REQ-035 SHALL check: 0x0000007F -> imm 0, tipo 7, invalido 1.
REQ-036 SHALL check: 3 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, 3rd held, all 3 emerge in order once out_ready=1.
REQ-037 SHALL check: reset asserted while in FULL -> next cycle out_valid 0, in_ready 1, buffered entries never appear.
